// File: rtl/entropy_conditioner_pkg.sv
// Shared types and defaults for the entropy conditioner.
// Optional health test is enabled by ENTROPY_HEALTH_TEST_EN.
package entropy_conditioner_pkg;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int BYTE_WIDTH_DEF  = 8;
    localparam int REP_LIMIT_DEF   = 32;

    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } pair_state_e;
endpackage

// File: rtl/entropy_conditioner_if.sv
// Valid/ready word channel between the conditioner and its consumer.
// Optional health test is enabled by ENTROPY_HEALTH_TEST_EN.
interface entropy_conditioner_if #(
    parameter int BYTE_WIDTH = entropy_conditioner_pkg::BYTE_WIDTH_DEF
);
    logic [BYTE_WIDTH-1:0] dataOut;
    logic                  dataValid;
    logic                  dataReady;

    modport master (
        output dataOut,
        output dataValid,
        input  dataReady
    );

    modport slave (
        input  dataOut,
        input  dataValid,
        output dataReady
    );
endinterface

// File: rtl/entropy_conditioner_bit_synchronizer.sv
// Plain flop-chain synchroniser with synchronous clear.
// Optional health test is enabled by ENTROPY_HEALTH_TEST_EN.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clkIn,
    input  logic rstIn,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clkIn) begin
        if (rstIn) chain <= '0;
        else       chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/entropy_conditioner.sv
// Sync, von Neumann debias and byte-pack an async raw bitstream.
// Optional health test is enabled by ENTROPY_HEALTH_TEST_EN.
module entropy_conditioner
    import entropy_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int BYTE_WIDTH  = BYTE_WIDTH_DEF,
    parameter int REP_LIMIT   = REP_LIMIT_DEF
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  rawBitIn,
    input  logic                  rawClkIn,
    entropy_conditioner_if.master bus,
    output logic                  overflowOut,
    output logic                  healthFailOut
);
    localparam int CW = $clog2(BYTE_WIDTH + 1);

    logic syncBit;
    logic syncClk;
    logic clkPrev;
    logic strobe;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_bit (
        .clkIn(clkIn), .rstIn(rstIn), .d(rawBitIn), .q(syncBit)
    );

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clkIn(clkIn), .rstIn(rstIn), .d(rawClkIn), .q(syncClk)
    );

    always_ff @(posedge clkIn) begin
        if (rstIn) clkPrev <= 1'b0;
        else       clkPrev <= syncClk;
    end

    // Raw bit changes on rising edges, so sample on the synced fall.
    assign strobe = clkPrev & ~syncClk;

    pair_state_e state;
    pair_state_e stateNext;
    logic        pairBit;
    logic        emit;
    logic        emitBit;

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state   <= FIRST;
            pairBit <= 1'b0;
        end else begin
            state <= stateNext;
            if (strobe && state == FIRST) pairBit <= syncBit;
        end
    end

    always_comb begin
        stateNext = state;
        if (strobe) begin
            unique case (state)
                FIRST:   stateNext = SECOND;
                SECOND:  stateNext = FIRST;
                default: stateNext = FIRST;
            endcase
        end
    end

    always_comb begin
        emit    = strobe && state == SECOND && pairBit != syncBit;
        emitBit = pairBit;
    end

    logic [BYTE_WIDTH-2:0] shiftReg;
    logic [BYTE_WIDTH-1:0] word;
    logic [CW-1:0]         bitCnt;
    logic                  complete;
    logic                  canLoad;
    logic                  xfer;
    logic                  gate;

    assign word     = {emitBit, shiftReg};
    assign complete = emit && bitCnt == CW'(BYTE_WIDTH - 1);
    assign xfer     = bus.dataValid && bus.dataReady;
    assign canLoad  = !bus.dataValid || bus.dataReady;

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            shiftReg      <= '0;
            bitCnt        <= '0;
            bus.dataOut   <= '0;
            bus.dataValid <= 1'b0;
            overflowOut   <= 1'b0;
        end else begin
            if (emit) begin
                shiftReg <= word[BYTE_WIDTH-1:1];
                bitCnt   <= complete ? '0 : bitCnt + 1'b1;
            end
            if (complete && !gate && canLoad) begin
                bus.dataOut   <= word;
                bus.dataValid <= 1'b1;
            end else if (xfer) begin
                bus.dataValid <= 1'b0;
            end
            if (complete && !gate && !canLoad) overflowOut <= 1'b1;
        end
    end

`ifdef ENTROPY_HEALTH_TEST_EN
    localparam int RW = $clog2(REP_LIMIT + 1);

    logic [RW-1:0] repCnt;
    logic          lastBit;
    logic          healthFail;
    logic          same;

    assign same = repCnt != '0 && syncBit == lastBit;

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            repCnt     <= '0;
            lastBit    <= 1'b0;
            healthFail <= 1'b0;
        end else if (strobe) begin
            lastBit <= syncBit;
            if (!same)                        repCnt <= RW'(1);
            else if (repCnt != RW'(REP_LIMIT)) repCnt <= repCnt + 1'b1;
            if (same && repCnt == RW'(REP_LIMIT - 1)) healthFail <= 1'b1;
        end
    end

    assign gate          = healthFail;
    assign healthFailOut = healthFail;
`else
    assign gate          = 1'b0;
    assign healthFailOut = 1'b0;
`endif
endmodule

// File: doc/entropy_conditioner.md
Name: entropy_conditioner

Overview:
- Downstream stage of the ring-oscillator generator. Consumes the slow serial raw bitstream and its companion bit clock, both asynchronous to the system clock.
- Synchronises both signals into the system clock domain and applies von Neumann debiasing.
- Packs the debiased bits into bytes and presents them on a valid/ready interface, for a UART or FIFO stage to drain.
- Optionally runs a repetition-count health test on the raw bits.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on rawBitIn and rawClkIn (minimum 2).
- BYTE_WIDTH, 8, number of debiased bits packed per output word.
- REP_LIMIT, 32, consecutive identical raw bits that trip the health test (minimum 2).

Ports:
- clkIn  in  1  system clock; the only clock in the block.
- rstIn  in  1  synchronous, active-high reset.
- rawBitIn  in  1  raw entropy bit; async; changes on rising edges of rawClkIn.
- rawClkIn  in  1  raw bit clock; async; period ≥ 4 clkIn periods.
- dataOut  out  BYTE_WIDTH  packed debiased word.
- dataValid  out  1  dataOut holds an unconsumed word.
- dataReady  in  1  consumer accepts the word.
- overflowOut  out  1  sticky; a completed word was dropped.
- healthFailOut  out  1  sticky; repetition-count test tripped.

Behaviour:
Reset
- On clkIn rising edge with rstIn=1: all synchroniser flops, pair state, bit counter, shift register and repetition counter clear.
- dataOut=0, dataValid=0, overflowOut=0, healthFailOut=0.
- Reset mid-word discards the partial word and any pending pair bit. No output appears the cycle after reset.

Synchronisation and sampling
- Both inputs pass through SYNC_STAGES flops.
- A falling edge of the synchronised clock (previous=1, current=0) generates a one-cycle sample strobe.
- On the strobe, the synchronised rawBitIn is sampled. The bit is stable there, because it changes on rising edges.
- Latency from the rawClkIn fall to the strobe is SYNC_STAGES+1 cycles.

Von Neumann pair FSM, states FIRST and SECOND
- FIRST: on strobe, store bit b0 and go to SECOND.
- SECOND: on strobe, take b1 and return to FIRST.
  - 01 → emit 0.
  - 10 → emit 1.
  - 00 or 11 → emit nothing.
- Pairs never overlap.

Packer
- Emitted bits shift in LSB-first: the first emitted bit ends up in dataOut[0].
- The bit counter runs 0..BYTE_WIDTH-1 and wraps to 0 on completion.
- On the completing bit:
  - If dataValid=0, or dataValid=1 and dataReady=1 in the same cycle, load dataOut and set dataValid=1 on the next edge. Simultaneous consume and refill produces no bubble.
  - Otherwise drop the word, keep the old dataOut, and set overflowOut=1.

Output handshake
- A transfer occurs when dataValid && dataReady.
- With no refill, dataValid clears on the next edge.
- dataOut is stable while dataValid=1 and dataReady=0.

Health test (ENTROPY_HEALTH_TEST_EN)
- A counter of consecutive equal raw samples resets to 1 on a change and saturates at REP_LIMIT.
- Reaching REP_LIMIT sets healthFailOut=1, sticky until rstIn.
- While healthFailOut=1, no new words are loaded, but the current word may still drain.

Optional Feature:
ENTROPY_HEALTH_TEST_EN
- Defined: the repetition-count test and gating are implemented as above.
- Undefined: no repetition counter is built, healthFailOut is tied to 0, and words are never gated.

Decomposition:
- Shared package holds:
  - pair FSM state encoding (FIRST=0, SECOND=1);
  - default constants SYNC_STAGES_DEF=2, BYTE_WIDTH_DEF=8, REP_LIMIT_DEF=32.
- One natural sub-module, bit_synchronizer: a parameterised flop chain used for both rawBitIn and rawClkIn, with rstIn clearing its flops.

Test Plan:
1. Raw bits 0,1 ×8 pairs (LSB-first debiased 0×8), dataReady=1 → dataOut=0x00, dataValid high for exactly one cycle.
2. Raw pairs 10,01,10,10,01,01,01,10 → dataOut=0x8D. Inserting 00 and 11 pairs anywhere leaves the result unchanged.
3. dataReady=0 and two complete words generated → first word 0x8D held stable, overflowOut=1 after the second completes. Raise dataReady → one transfer, dataValid=0.
4. Word completion and dataReady=1 in the same cycle → dataValid remains 1 and dataOut updates with no gap.
5. Macro defined, 32 consecutive raw 1s → healthFailOut=1 on the 32nd strobe, no further words. Repeat with the macro undefined → healthFailOut stays 0.
6. Assert rstIn after 5 debiased bits → all outputs 0. The next 8 debiased bits form a fresh word and earlier bits do not appear.
